// File: rtl/axicb_pkg.sv
// Shared types and defaults for the AXI crossbar read-path blocks.
package axicb_pkg;

    localparam int AXICB_MAX_OST_DEF = 8;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } axicb_rd_state_e;

endpackage

// File: rtl/axicb_ost_counter.sv
// Single-master outstanding read burst counter with sticky underflow flag.
// The R-silence watchdog is built only when AXICB_RD_OST_TIMEOUT_EN is defined.
module axicb_ost_counter
    import axicb_pkg::*;
#(
    parameter int MAX_OST        = AXICB_MAX_OST_DEF,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(MAX_OST + 1)
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic srst,
    input  logic inc,
    input  logic dec,
    input  logic r_hs,
    output logic full,
    output logic empty,
    output logic underflow,
    output logic timeout
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             underflow_q, underflow_d;

    assign full  = (cnt_q == CNT_W'(MAX_OST));
    assign empty = (cnt_q == '0);

    // inc is already gated by full upstream, so +1 cannot overshoot MAX_OST
    always_comb begin
        cnt_d       = cnt_q;
        underflow_d = underflow_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc) begin
            if (empty) underflow_d = 1'b1;
            else       cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else if (srst) begin
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign underflow = underflow_q;

`ifdef AXICB_RD_OST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            timeout_q, timeout_d;

    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        if (empty || r_hs)                       wdog_d = '0;
        else if (wdog_q != WD_W'(TIMEOUT_CYCLES)) wdog_d = wdog_q + WD_W'(1);
        if (wdog_d == WD_W'(TIMEOUT_CYCLES))     timeout_d = 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else if (srst) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_r_hs;
    assign unused_r_hs = r_hs;
    assign timeout     = 1'b0;
`endif

endmodule

// File: rtl/axicb_rd_ost_ctrl.sv
// Read-path admission control: per-master outstanding limit plus drain/quiesce FSM.
// Optional per-master R watchdog via AXICB_RD_OST_TIMEOUT_EN.
// Integrator note: a reset mid-burst clears the counters, so late RLASTs then flag err_underflow.
//   state      | meaning
//   ST_RUN     | AR admitted subject to per-master limit
//   ST_DRAIN   | AR blocked, waiting for all bursts to complete
//   ST_DRAINED | AR blocked, fabric idle, drained asserted
module axicb_rd_ost_ctrl
    import axicb_pkg::*;
#(
    parameter int  MST_NB         = 4,
    parameter int  MAX_OST        = AXICB_MAX_OST_DEF,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int CNT_W          = $clog2(MAX_OST + 1)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic [MST_NB-1:0] s_arvalid,
    output logic [MST_NB-1:0] s_arready,
    output logic [MST_NB-1:0] m_arvalid,
    input  logic [MST_NB-1:0] m_arready,
    input  logic [MST_NB-1:0] r_valid,
    input  logic [MST_NB-1:0] r_ready,
    input  logic [MST_NB-1:0] r_last,
    input  logic              drain_req,
    output logic              drained,
    output logic [MST_NB-1:0] ost_full,
    output logic              ost_busy,
    output logic              err_underflow,
    output logic [MST_NB-1:0] err_timeout
);

    axicb_rd_state_e state_q, state_d;

    logic [MST_NB-1:0] block;
    logic [MST_NB-1:0] inc;
    logic [MST_NB-1:0] dec;
    logic [MST_NB-1:0] r_hs;
    logic [MST_NB-1:0] empty;
    logic [MST_NB-1:0] underflow;

    // block depends only on registered state, keeping r_* off the AR paths
    assign block     = ost_full | {MST_NB{state_q != ST_RUN}};
    assign m_arvalid = s_arvalid & ~block;
    assign s_arready = m_arready & ~block;

    assign inc  = s_arvalid & s_arready;
    assign r_hs = r_valid & r_ready;
    assign dec  = r_hs & r_last;

    for (genvar i = 0; i < MST_NB; i++) begin : g_cnt
        axicb_ost_counter #(
            .MAX_OST        (MAX_OST),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cnt (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .srst      (srst),
            .inc       (inc[i]),
            .dec       (dec[i]),
            .r_hs      (r_hs[i]),
            .full      (ost_full[i]),
            .empty     (empty[i]),
            .underflow (underflow[i]),
            .timeout   (err_timeout[i])
        );
    end

    assign ost_busy      = ~&empty;
    assign err_underflow = |underflow;
    assign drained       = (state_q == ST_DRAINED);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (drain_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_req)                   state_d = ST_RUN;
                else if (!ost_busy && dec == '0)  state_d = ST_DRAINED;
            end
            ST_DRAINED: begin
                if (!drain_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)  state_q <= ST_RUN;
        else if (srst) state_q <= ST_RUN;
        else           state_q <= state_d;
    end

endmodule

// File: tb/tb_axicb_rd_ost_ctrl.sv
// Directed bench for axicb_rd_ost_ctrl with MAX_OST=2, TIMEOUT_CYCLES=16.
module tb_axicb_rd_ost_ctrl;

    localparam int MST_NB = 4;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              srst;
    logic [MST_NB-1:0] s_arvalid;
    logic [MST_NB-1:0] s_arready;
    logic [MST_NB-1:0] m_arvalid;
    logic [MST_NB-1:0] m_arready;
    logic [MST_NB-1:0] r_valid;
    logic [MST_NB-1:0] r_ready;
    logic [MST_NB-1:0] r_last;
    logic              drain_req;
    logic              drained;
    logic [MST_NB-1:0] ost_full;
    logic              ost_busy;
    logic              err_underflow;
    logic [MST_NB-1:0] err_timeout;

    int total = 0;
    int bad   = 0;

    axicb_rd_ost_ctrl #(
        .MST_NB         (MST_NB),
        .MAX_OST        (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .srst          (srst),
        .s_arvalid     (s_arvalid),
        .s_arready     (s_arready),
        .m_arvalid     (m_arvalid),
        .m_arready     (m_arready),
        .r_valid       (r_valid),
        .r_ready       (r_ready),
        .r_last        (r_last),
        .drain_req     (drain_req),
        .drained       (drained),
        .ost_full      (ost_full),
        .ost_busy      (ost_busy),
        .err_underflow (err_underflow),
        .err_timeout   (err_timeout)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_r(input logic [3:0] v, input logic [3:0] last);
        r_valid = v;
        r_ready = v;
        r_last  = last;
    endtask

    logic [3:0] exp_to;

    initial begin
        aresetn   = 1'b0;
        srst      = 1'b0;
        s_arvalid = '0;
        m_arready = '0;
        set_r(4'b0000, 4'b0000);
        drain_req = 1'b0;
        repeat (2) tick();
        settle();
        chk("rst_s_arready", 32'(s_arready), 32'h0);
        chk("rst_m_arvalid", 32'(m_arvalid), 32'h0);
        chk("rst_ost_full", 32'(ost_full), 32'h0);
        chk("rst_ost_busy", 32'(ost_busy), 32'h0);
        chk("rst_drained", 32'(drained), 32'h0);
        chk("rst_err_uf", 32'(err_underflow), 32'h0);
        chk("rst_err_to", 32'(err_timeout), 32'h0);
        aresetn = 1'b1;
        tick();

        // master0 fills to MAX_OST=2
        m_arready = 4'hF;
        s_arvalid = 4'b0001;
        settle();
        chk("ar0_first_valid", 32'(m_arvalid), 32'h1);
        chk("ar0_first_ready", 32'(s_arready), 32'hF);
        tick();
        settle();
        chk("ar0_one_full", 32'(ost_full), 32'h0);
        chk("ar0_one_busy", 32'(ost_busy), 32'h1);
        tick();
        settle();
        chk("ar0_two_full", 32'(ost_full), 32'h1);
        chk("ar0_two_ready", 32'(s_arready), 32'hE);
        chk("ar0_two_valid", 32'(m_arvalid), 32'h0);
        s_arvalid = 4'b0011;
        settle();
        chk("ar1_while0_full", 32'(m_arvalid), 32'h2);
        tick();

        // RLAST frees a slot one cycle later; no comb path from R to AR
        s_arvalid = 4'b0001;
        set_r(4'b0001, 4'b0001);
        settle();
        chk("rlast_no_comb", 32'(s_arready), 32'hE);
        tick();
        set_r(4'b0000, 4'b0000);
        settle();
        chk("rlast_full_clr", 32'(ost_full), 32'h0);
        chk("rlast_ready_back", 32'(s_arready), 32'hF);
        tick();
        s_arvalid = 4'b0000;
        settle();
        chk("ar0_third_full", 32'(ost_full), 32'h1);
        set_r(4'b0001, 4'b0001);
        tick();

        // master2: simultaneous inc/dec, then non-last beats
        set_r(4'b0000, 4'b0000);
        s_arvalid = 4'b0100;
        tick();
        set_r(4'b0100, 4'b0100);
        tick();
        s_arvalid = 4'b0000;
        set_r(4'b0000, 4'b0000);
        settle();
        chk("m2_incdec_full", 32'(ost_full), 32'h0);
        s_arvalid = 4'b0100;
        tick();
        s_arvalid = 4'b0000;
        settle();
        chk("m2_two_full", 32'(ost_full), 32'h4);
        set_r(4'b0100, 4'b0000);
        repeat (2) tick();
        set_r(4'b0000, 4'b0000);
        settle();
        chk("m2_nonlast_full", 32'(ost_full), 32'h4);
        set_r(4'b0100, 4'b0100);
        repeat (2) tick();
        set_r(4'b0000, 4'b0000);
        settle();
        chk("m2_empty_full", 32'(ost_full), 32'h0);
        chk("m2_empty_busy", 32'(ost_busy), 32'h1);

        // drain with cnt0=1, cnt1=1; AR on master3 still lands in the request cycle
        drain_req = 1'b1;
        s_arvalid = 4'b1000;
        settle();
        chk("drain_first_cycle", 32'(s_arready), 32'hF);
        tick();
        s_arvalid = 4'hF;
        settle();
        chk("drain_blk_valid", 32'(m_arvalid), 32'h0);
        chk("drain_blk_ready", 32'(s_arready), 32'h0);
        chk("drain_not_done", 32'(drained), 32'h0);
        set_r(4'b1001, 4'b1001);
        tick();
        set_r(4'b0010, 4'b0010);
        tick();
        set_r(4'b0000, 4'b0000);
        settle();
        chk("drain_idle_busy", 32'(ost_busy), 32'h0);
        chk("drain_idle_valid", 32'(m_arvalid), 32'h0);
        tick();
        settle();
        chk("drained_set", 32'(drained), 32'h1);
        chk("drained_valid", 32'(m_arvalid), 32'h0);
        drain_req = 1'b0;
        s_arvalid = 4'h0;
        settle();
        chk("drained_reg", 32'(drained), 32'h1);
        tick();
        settle();
        chk("run_drained_clr", 32'(drained), 32'h0);
        chk("run_ready_back", 32'(s_arready), 32'hF);

        // underflow on master3, sticky, cleared by srst
        set_r(4'b1000, 4'b1000);
        settle();
        chk("uf_before", 32'(err_underflow), 32'h0);
        tick();
        set_r(4'b0000, 4'b0000);
        settle();
        chk("uf_set", 32'(err_underflow), 32'h1);
        chk("uf_cnt_zero", 32'(ost_busy), 32'h0);
        tick();
        settle();
        chk("uf_sticky", 32'(err_underflow), 32'h1);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        settle();
        chk("uf_srst_clr", 32'(err_underflow), 32'h0);

        // watchdog: master0 silent, master1 gets a non-last beat every 10 cycles
`ifdef AXICB_RD_OST_TIMEOUT_EN
        exp_to = 4'b0001;
`else
        exp_to = 4'b0000;
`endif
        s_arvalid = 4'b0001;
        tick();
        s_arvalid = 4'b0000;
        repeat (15) tick();
        settle();
        chk("to_before", 32'(err_timeout), 32'h0);
        tick();
        settle();
        chk("to_reached", 32'(err_timeout), 32'(exp_to));
        s_arvalid = 4'b0010;
        tick();
        s_arvalid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            repeat (9) tick();
            set_r(4'b0010, 4'b0000);
            tick();
            set_r(4'b0000, 4'b0000);
        end
        settle();
        chk("to_kept_alive", 32'(err_timeout[1]), 32'h0);
        chk("to_sticky", 32'(err_timeout), 32'(exp_to));

        // async reset mid-burst with underflow pending
        set_r(4'b0100, 4'b0100);
        tick();
        set_r(4'b0000, 4'b0000);
        settle();
        chk("pre_rst_uf", 32'(err_underflow), 32'h1);
        m_arready = 4'h0;
        aresetn   = 1'b0;
        settle();
        chk("arst_busy", 32'(ost_busy), 32'h0);
        chk("arst_full", 32'(ost_full), 32'h0);
        chk("arst_ready", 32'(s_arready), 32'h0);
        chk("arst_valid", 32'(m_arvalid), 32'h0);
        chk("arst_drained", 32'(drained), 32'h0);
        chk("arst_uf", 32'(err_underflow), 32'h0);
        chk("arst_to", 32'(err_timeout), 32'h0);
        aresetn = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
